conv8_accum: RTL and testbench
==============================

Name: conv8_accum

Overview:
- Downstream stage of the 8-row 3-tap convolution core; consumes its four partial-sum lanes each time the core signals completion.
- Accumulates partial sums across input channels, then adds bias, rounds, shifts, optionally applies ReLU, and saturates to signed 8-bit.
- Buffers finished 4-pixel output groups in a small FIFO with a valid/ready interface to the write-back stage.
- One tile = cfg_npix output groups × cfg_nch input channels.

Parameters:
- W, conv8_width (package), operand width; input sums are 2*W wide.
- MAX_CH, 64, maximum input channels per output; ACC_W = 2*W + clog2(MAX_CH).
- FIFO_DEPTH, 4, output group FIFO depth (power of two).
- MAX_PIX, 1024, maximum output groups per tile.

Ports:
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- i_start  in  1  one-cycle pulse; latches cfg_*, clears counters/accumulators; ignored unless IDLE.
- cfg_nch  in  clog2(MAX_CH)+1  channels per output, 1..MAX_CH.
- cfg_npix  in  clog2(MAX_PIX)+1  output groups per tile, 1..MAX_PIX.
- cfg_shift  in  4  right-shift amount 0..15.
- cfg_relu  in  1  1 = clamp negatives to 0.
- i_bias  in  2*W  signed bias; sampled on each final-channel beat.
- in_valid  in  1  sum beat valid (driven from the core's end flag).
- in_ready  out  1  accept beat.
- i_sum1..i_sum4  in  2*W each  signed partial sums, lanes 1..4.
- o_valid  out  1  FIFO head valid.
- o_ready  in  1  consumer ready.
- o_data  out  4*W  {lane4,lane3,lane2,lane1} signed W-bit results; lane1 is in the LSBs.
- o_busy  out  1  high from start until the tile is fully written into the FIFO.
- o_done  out  1  one-cycle pulse when the last group of the tile enters the FIFO.

Behaviour:
- Reset values: all outputs 0; FIFO empty; counters 0; state IDLE.
- Beat acceptance: a beat is accepted on a rising edge with in_valid && in_ready.
- States:
  - IDLE: i_start goes to RUN and sets o_busy.
  - RUN: accepts beats; after the final beat of the last group goes to DRAIN.
  - DRAIN: waits for the pipeline to empty, pulses o_done, returns to IDLE, clears o_busy.
- in_ready = (state==RUN) && (fifo_count + pipe_occupancy < FIFO_DEPTH). Ready must not depend combinationally on in_valid.
- ch_cnt increments per accepted beat.
  - ch_cnt==0: acc = sext(sum); otherwise acc = acc + sext(sum), per lane, at width ACC_W.
  - ch_cnt==cfg_nch-1 (final beat): ch_cnt wraps to 0, pix_cnt increments, and the group launches into the post pipeline.
- Post pipeline, per lane, two register stages:
  - S1: v = acc_final + sext(i_bias) + (cfg_shift ? 1<<(cfg_shift-1) : 0).
  - S2: y = v >>> cfg_shift, arithmetic shift. If cfg_relu and y<0 then y=0. Saturate to [-2^(W-1), 2^(W-1)-1].
  - The FIFO write occurs on the S2 edge; o_valid rises the cycle after it.
  - Latency: final beat accepted at edge t → FIFO write at edge t+2.
- The accumulator for the next group may restart at edge t+1 with no bubble.
- cfg_nch==1: every beat is final; acc_final = that beat's sum.
- FIFO:
  - Simultaneous push and pop when full is legal, since in_ready already reserved the slot.
  - Pop with o_valid && o_ready.
  - o_data is registered FIFO head data, stable while o_valid && !o_ready.
- Wrap-around: pointers wrap modulo FIFO_DEPTH; the count distinguishes full from empty.
- Done: o_done pulses in the cycle after the last group's FIFO write edge. The FIFO may still hold data; the consumer drains it normally.
- i_start during RUN or DRAIN is ignored, with no state change.
- Asynchronous reset mid-tile: immediately flushes the FIFO and pipeline and drops o_valid, o_busy and in_ready; partial accumulations are lost.

Decomposition:
- Package definition gains:
  - ACC_W, MAX_CH, MAX_PIX, FIFO_DEPTH constants.
  - typedef acc_t (signed [ACC_W-1:0]).
  - typedef psum_t (signed [2*W-1:0]).
  - typedef q_t (signed [W-1:0]).
  - enum accum_state_t {IDLE, RUN, DRAIN}.
- One natural sub-module: requant_lane, the per-lane bias/round/shift/relu/saturate stage, instantiated four times. The FIFO is inline.

Test Plan:
- W=8, cfg_nch=3, npix=1, shift=0, relu=0, bias=0; lane1 sums 10, 20, 30 → o_data lane1 = 60 at edge t+2; o_done pulses once.
- cfg_nch=1, shift=4, bias=8; sum=100 → (100+8+8)>>>4 = 7. Sum=-200 → (-200+8+8)>>>4 = -12.
- Saturation: cfg_nch=2, sums 30000 and 30000, shift=0 → 127. With sums -30000, -30000 and relu=0 → -128; with relu=1 → 0.
- Backpressure: npix=8, cfg_nch=1, o_ready=0 → in_ready drops after 4 groups in FIFO/pipeline; raise o_ready → all 8 groups emerge in order, none lost or duplicated.
- Streaming: o_ready=1, in_valid=1 every cycle, npix=16, cfg_nch=2 → 16 outputs, one per 2 cycles; no in_ready bubbles; o_busy low after o_done.
- Reset: assert rstn=0 mid-tile with 2 groups in FIFO → o_valid=0 and FIFO empty immediately; a new i_start after release runs a fresh tile correctly.

Source files
------------

// File: rtl/conv8_accum_pkg.sv
// conv8_accum shared types and constants.
// Widths derive from the convolution core operand width.
package conv8_accum_pkg;
    localparam int conv8_width = 8;
    localparam int W          = conv8_width;
    localparam int MAX_CH     = 64;
    localparam int MAX_PIX    = 1024;
    localparam int FIFO_DEPTH = 4;
    localparam int CH_W       = $clog2(MAX_CH) + 1;
    localparam int PIX_W      = $clog2(MAX_PIX) + 1;
    localparam int ACC_W      = 2 * W + $clog2(MAX_CH);
    localparam int V_W        = ACC_W + 2;
    localparam int PTR_W      = $clog2(FIFO_DEPTH);
    localparam int CNT_W      = PTR_W + 1;
    localparam int OCC_W      = CNT_W + 1;

    typedef logic signed [ACC_W-1:0] acc_t;
    typedef logic signed [2*W-1:0]   psum_t;
    typedef logic signed [W-1:0]     q_t;
    typedef logic [OCC_W-1:0]        occ_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } accum_state_t;
endpackage

// File: rtl/conv8_accum_if.sv
// Beat input and group output handshakes of conv8_accum.
// master = upstream core / write-back side, slave = accumulator.
interface conv8_accum_if;
    import conv8_accum_pkg::*;

    logic             in_valid;
    logic             in_ready;
    psum_t            i_sum1;
    psum_t            i_sum2;
    psum_t            i_sum3;
    psum_t            i_sum4;
    psum_t            i_bias;
    logic             o_valid;
    logic             o_ready;
    logic [4*W-1:0]   o_data;

    modport master (
        output in_valid, i_sum1, i_sum2, i_sum3, i_sum4, i_bias, o_ready,
        input  in_ready, o_valid, o_data
    );

    modport slave (
        input  in_valid, i_sum1, i_sum2, i_sum3, i_sum4, i_bias, o_ready,
        output in_ready, o_valid, o_data
    );
endinterface

// File: rtl/conv8_accum_requant.sv
// Per-lane requantiser: S1 adds bias and rounding,
// S2 (combinational here, registered by the FIFO) shifts, relus, saturates.
module requant_lane
    import conv8_accum_pkg::*;
(
    input  logic       clk,
    input  logic       rstn,
    input  logic       i_en,
    input  acc_t       i_acc,
    input  psum_t      i_bias,
    input  logic [3:0] i_shift,
    input  logic       i_relu,
    output q_t         o_y
);
    typedef logic signed [V_W-1:0] v_t;

    localparam v_t QMAX = v_t'((1 << (W - 1)) - 1);
    localparam v_t QMIN = ~QMAX;

    v_t r_v;
    v_t w_rnd;
    v_t w_sum;
    v_t w_y;
    v_t w_c;

    // bias plus half-LSB rounding term
    always_comb begin
        w_rnd = '0;
        if (i_shift != 4'd0) begin
            w_rnd[i_shift - 4'd1] = 1'b1;
        end
        w_sum = v_t'(i_acc) + v_t'(i_bias) + w_rnd;
    end

    // S1 register, loaded when a finished group arrives
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_v <= '0;
        end else if (i_en) begin
            r_v <= w_sum;
        end
    end

    // arithmetic shift, optional relu, clamp to W bits
    always_comb begin
        w_y = r_v >>> i_shift;
        w_c = w_y;
        if (i_relu && w_y[V_W-1]) begin
            w_c = '0;
        end else if (w_y > QMAX) begin
            w_c = QMAX;
        end else if (w_y < QMIN) begin
            w_c = QMIN;
        end
        o_y = q_t'(w_c);
    end
endmodule

// File: rtl/conv8_accum.sv
// Channel accumulator with requantise pipeline and output group FIFO.
// in_ready reserves a FIFO slot for every group still in flight.
module conv8_accum
    import conv8_accum_pkg::*;
(
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_start,
    input  logic [CH_W-1:0]  cfg_nch,
    input  logic [PIX_W-1:0] cfg_npix,
    input  logic [3:0]       cfg_shift,
    input  logic             cfg_relu,
    conv8_accum_if.slave     bus,
    output logic             o_busy,
    output logic             o_done
);
    localparam logic [1:0] ST_IDLE  = IDLE;
    localparam logic [1:0] ST_RUN   = RUN;
    localparam logic [1:0] ST_DRAIN = DRAIN;

    logic [1:0]       r_state;
    logic [CH_W-1:0]  r_nch;
    logic [CH_W-1:0]  r_ch;
    logic [PIX_W-1:0] r_npix;
    logic [PIX_W-1:0] r_pix;
    logic [3:0]       r_shift;
    logic             r_relu;
    logic             r_busy;
    logic             r_done;
    acc_t             r_acc [4];
    psum_t            r_bias;
    logic             r_fin;
    logic             r_s1v;
    logic [4*W-1:0]   r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wp;
    logic [PTR_W-1:0] r_rp;
    logic [CNT_W-1:0] r_cnt;

    psum_t            w_sum [4];
    acc_t             w_acc [4];
    q_t               w_y [4];
    occ_t             w_occ;
    logic             w_ready;
    logic             w_acc_en;
    logic             w_last_ch;
    logic             w_last_pix;
    logic             w_fin;
    logic             w_push;
    logic             w_pop;

    assign w_sum[0]   = bus.i_sum1;
    assign w_sum[1]   = bus.i_sum2;
    assign w_sum[2]   = bus.i_sum3;
    assign w_sum[3]   = bus.i_sum4;
    assign w_occ      = occ_t'(r_cnt) + occ_t'(r_fin) + occ_t'(r_s1v);
    assign w_ready    = (r_state == ST_RUN) && (w_occ < occ_t'(FIFO_DEPTH));
    assign w_acc_en   = bus.in_valid && w_ready;
    assign w_last_ch  = (r_ch == r_nch - CH_W'(1));
    assign w_last_pix = (r_pix == r_npix - PIX_W'(1));
    assign w_fin      = w_acc_en && w_last_ch;
    assign w_push     = r_s1v;
    assign w_pop      = (r_cnt != '0) && bus.o_ready;

    assign bus.in_ready = w_ready;
    assign bus.o_valid  = (r_cnt != '0);
    assign bus.o_data   = r_mem[r_rp];
    assign o_busy       = r_busy;
    assign o_done       = r_done;

    // first channel loads, later channels add
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            if (r_ch == '0) begin
                w_acc[i] = acc_t'(w_sum[i]);
            end else begin
                w_acc[i] = r_acc[i] + acc_t'(w_sum[i]);
            end
        end
    end

    // tile control: config latch, busy and done
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nch   <= '0;
            r_npix  <= '0;
            r_shift <= '0;
            r_relu  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b1;
                        r_nch   <= cfg_nch;
                        r_npix  <= cfg_npix;
                        r_shift <= cfg_shift;
                        r_relu  <= cfg_relu;
                    end
                end
                ST_RUN: begin
                    if (w_fin && w_last_pix) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (r_s1v && !r_fin) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // channel/pixel counters, accumulators, final-beat bias
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ch   <= '0;
            r_pix  <= '0;
            r_bias <= '0;
            r_fin  <= 1'b0;
            r_s1v  <= 1'b0;
            for (int i = 0; i < 4; i++) r_acc[i] <= '0;
        end else begin
            r_fin <= w_fin;
            r_s1v <= r_fin;
            if (i_start && r_state == ST_IDLE) begin
                r_ch  <= '0;
                r_pix <= '0;
                for (int i = 0; i < 4; i++) r_acc[i] <= '0;
            end else if (w_acc_en) begin
                r_ch <= w_last_ch ? '0 : r_ch + CH_W'(1);
                for (int i = 0; i < 4; i++) r_acc[i] <= w_acc[i];
                if (w_last_ch) begin
                    r_pix  <= r_pix + PIX_W'(1);
                    r_bias <= bus.i_bias;
                end
            end
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_lane
        requant_lane u_rq (
            .clk     (clk),
            .rstn    (rstn),
            .i_en    (r_fin),
            .i_acc   (r_acc[g]),
            .i_bias  (r_bias),
            .i_shift (r_shift),
            .i_relu  (r_relu),
            .o_y     (w_y[g])
        );
    end

    // output group FIFO; S2 edge is the write
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wp] <= {w_y[3], w_y[2], w_y[1], w_y[0]};
                r_wp        <= r_wp + PTR_W'(1);
            end
            if (w_pop) begin
                r_rp <= r_rp + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else if (!w_push && w_pop) begin
                r_cnt <= r_cnt - CNT_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_conv8_accum.sv
// Directed self-checking bench for conv8_accum.
// Inputs change and outputs are sampled on the falling edge.
module tb_conv8_accum;
    import conv8_accum_pkg::*;

    logic             clk = 1'b0;
    logic             rstn;
    logic             i_start;
    logic [CH_W-1:0]  cfg_nch;
    logic [PIX_W-1:0] cfg_npix;
    logic [3:0]       cfg_shift;
    logic             cfg_relu;
    logic             o_busy;
    logic             o_done;
    int               n_cmp = 0;
    int               n_fail = 0;

    conv8_accum_if bus ();

    conv8_accum dut (
        .clk       (clk),
        .rstn      (rstn),
        .i_start   (i_start),
        .cfg_nch   (cfg_nch),
        .cfg_npix  (cfg_npix),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .bus       (bus),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    task automatic idle_inputs();
        i_start      = 1'b0;
        cfg_nch      = '0;
        cfg_npix     = '0;
        cfg_shift    = '0;
        cfg_relu     = 1'b0;
        bus.in_valid = 1'b0;
        bus.i_sum1   = '0;
        bus.i_sum2   = '0;
        bus.i_sum3   = '0;
        bus.i_sum4   = '0;
        bus.i_bias   = '0;
        bus.o_ready  = 1'b0;
    endtask

    task automatic do_start(input int nch, input int npix,
                            input int sh, input int relu);
        @(negedge clk);
        cfg_nch   = CH_W'(nch);
        cfg_npix  = PIX_W'(npix);
        cfg_shift = 4'(sh);
        cfg_relu  = relu[0];
        i_start   = 1'b1;
        @(negedge clk);
        i_start   = 1'b0;
    endtask

    task automatic set_beat(input int s1, input int s2, input int s3,
                            input int s4, input int b);
        bus.i_sum1 = psum_t'(s1);
        bus.i_sum2 = psum_t'(s2);
        bus.i_sum3 = psum_t'(s3);
        bus.i_sum4 = psum_t'(s4);
        bus.i_bias = psum_t'(b);
    endtask

    // returns at the falling edge after the accepting edge
    task automatic send_beat(input int s1, input int s2, input int s3,
                             input int s4, input int b, output bit ok);
        set_beat(s1, s2, s3, s4, b);
        bus.in_valid = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (bus.in_ready) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pop_word(output logic [31:0] d, output bit ok);
        ok = 1'b0;
        d  = '0;
        for (int k = 0; k < 200; k++) begin
            if (bus.o_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (ok) begin
            d = bus.o_data;
            bus.o_ready = 1'b1;
            @(negedge clk);
            bus.o_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        logic [3:0] flags;
        rstn = 1'b0;
        idle_inputs();
        #12;
        flags = {bus.o_valid, o_busy, o_done, bus.in_ready};
        n_cmp++;
        if (flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got %b expected 0000", flags);
        end
        n_cmp++;
        if (bus.o_data !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_data: got %h expected 00000000", bus.o_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_accum();
        bit ok;
        bit okall;
        logic [2:0] f;
        logic [31:0] d;
        okall = 1'b1;
        do_start(3, 1, 0, 0);
        send_beat(10, 1, -5, 0, 0, ok);
        okall &= ok;
        cfg_nch = CH_W'(1);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        cfg_nch = CH_W'(3);
        send_beat(20, 2, -5, 0, 0, ok);
        okall &= ok;
        send_beat(30, 3, -5, 0, 0, ok);
        okall &= ok;
        n_cmp++;
        if (okall !== 1'b1 || bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accum_t0: accepted=%b o_valid=%b expected 1 0",
                     okall, bus.o_valid);
        end
        @(negedge clk);
        f = {bus.o_valid, o_done, o_busy};
        n_cmp++;
        if (f !== 3'b001) begin
            n_fail++;
            $display("FAIL accum_t1 {valid,done,busy}: got %b expected 001", f);
        end
        @(negedge clk);
        f = {bus.o_valid, o_done, o_busy};
        n_cmp++;
        if (f !== 3'b110) begin
            n_fail++;
            $display("FAIL accum_t2 {valid,done,busy}: got %b expected 110", f);
        end
        n_cmp++;
        if (bus.o_data !== 32'h00F1063C) begin
            n_fail++;
            $display("FAIL accum_data: got %h expected 00f1063c", bus.o_data);
        end
        @(negedge clk);
        n_cmp++;
        if (o_done !== 1'b0) begin
            n_fail++;
            $display("FAIL accum_done_pulse: got %b expected 0", o_done);
        end
        pop_word(d, ok);
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL accum_empty: got o_valid=%b expected 0", bus.o_valid);
        end
    endtask

    task automatic test_round();
        bit ok;
        logic [31:0] d;
        do_start(1, 2, 4, 0);
        send_beat(100, -200, 0, 15, 8, ok);
        send_beat(-200, 100, -16, -17, 8, ok);
        pop_word(d, ok);
        n_cmp++;
        if (!ok || d !== 32'h0101F407) begin
            n_fail++;
            $display("FAIL round_g0: got %h ok=%b expected 0101f407", d, ok);
        end
        pop_word(d, ok);
        n_cmp++;
        if (!ok || d !== 32'hFF0007F4) begin
            n_fail++;
            $display("FAIL round_g1: got %h ok=%b expected ff0007f4", d, ok);
        end
        n_cmp++;
        if (o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL round_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_saturate();
        bit ok;
        logic [31:0] d;
        do_start(2, 2, 0, 0);
        send_beat(30000, -30000, 100, -100, 0, ok);
        send_beat(30000, -30000, 28, -28, 0, ok);
        send_beat(10, 0, 127, -128, 1000, ok);
        send_beat(10, 0, 0, 0, -5, ok);
        pop_word(d, ok);
        n_cmp++;
        if (!ok || d !== 32'h807F807F) begin
            n_fail++;
            $display("FAIL sat_clamp: got %h ok=%b expected 807f807f", d, ok);
        end
        pop_word(d, ok);
        n_cmp++;
        if (!ok || d !== 32'h807AFB0F) begin
            n_fail++;
            $display("FAIL sat_bias: got %h ok=%b expected 807afb0f", d, ok);
        end
        do_start(2, 1, 0, 1);
        send_beat(-30000, 30000, -1, 5, 0, ok);
        send_beat(-30000, 30000, 0, 6, 0, ok);
        pop_word(d, ok);
        n_cmp++;
        if (!ok || d !== 32'h0B007F00) begin
            n_fail++;
            $display("FAIL sat_relu: got %h ok=%b expected 0b007f00", d, ok);
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        bit okall;
        bit okpop;
        logic [31:0] got [8];
        logic [31:0] exp;
        int bad;
        okall = 1'b1;
        okpop = 1'b1;
        bad = 0;
        bus.o_ready = 1'b0;
        do_start(1, 8, 0, 0);
        for (int k = 0; k < 4; k++) begin
            send_beat(k + 1, -(k + 1), 16 + k, 85, 0, ok);
            okall &= ok;
        end
        n_cmp++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_drop: got %b expected 0", bus.in_ready);
        end
        repeat (3) @(negedge clk);
        n_cmp++;
        if (bus.in_ready !== 1'b0 || bus.o_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_hold: in_ready=%b o_valid=%b expected 0 1",
                     bus.in_ready, bus.o_valid);
        end
        fork
            begin
                for (int k = 4; k < 8; k++) begin
                    send_beat(k + 1, -(k + 1), 16 + k, 85, 0, ok);
                    okall &= ok;
                end
            end
            begin
                for (int j = 0; j < 8; j++) begin
                    logic [31:0] w;
                    bit pk;
                    pop_word(w, pk);
                    got[j] = w;
                    okpop &= pk;
                end
            end
        join
        for (int k = 0; k < 8; k++) begin
            exp = {8'h55, 8'(16 + k), 8'(-(k + 1)), 8'(k + 1)};
            if (got[k] !== exp) bad++;
        end
        n_cmp++;
        if (bad != 0 || !okall || !okpop) begin
            n_fail++;
            $display("FAIL bp_order: got %0d bad words (send=%b pop=%b) expected 0",
                     bad, okall, okpop);
        end
        n_cmp++;
        if (bus.o_valid !== 1'b0 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_end: o_valid=%b o_busy=%b expected 0 0",
                     bus.o_valid, o_busy);
        end
    endtask

    task automatic test_stream();
        logic [31:0] q [$];
        int bubbles;
        int dones;
        int gaps;
        int bad;
        int last;
        logic [31:0] exp;
        bubbles = 0;
        dones = 0;
        gaps = 0;
        bad = 0;
        last = -1;
        do_start(2, 16, 0, 0);
        bus.o_ready = 1'b1;
        fork
            begin
                for (int b = 0; b < 32; b++) begin
                    int g;
                    g = b / 2;
                    if (b % 2 == 0) set_beat(g, -g, 3, 4 * g, 0);
                    else set_beat(1, -g, 4, 0, 0);
                    bus.in_valid = 1'b1;
                    if (!bus.in_ready) begin
                        bubbles++;
                        for (int k = 0; k < 50 && !bus.in_ready; k++) begin
                            @(negedge clk);
                        end
                    end
                    @(negedge clk);
                end
                bus.in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 100; c++) begin
                    @(negedge clk);
                    if (bus.o_valid) begin
                        q.push_back(bus.o_data);
                        if (last >= 0 && c - last != 2) gaps++;
                        last = c;
                    end
                    if (o_done) dones++;
                end
            end
        join
        bus.o_ready = 1'b0;
        n_cmp++;
        if (q.size() != 16) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected 16", q.size());
        end
        for (int g = 0; g < 16 && g < q.size(); g++) begin
            exp = {8'(4 * g), 8'd7, 8'(-2 * g), 8'(g + 1)};
            if (q[g] !== exp) bad++;
        end
        n_cmp++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream_data: got %0d bad words expected 0", bad);
        end
        n_cmp++;
        if (bubbles != 0 || gaps != 0) begin
            n_fail++;
            $display("FAIL stream_rate: bubbles=%0d gaps=%0d expected 0 0",
                     bubbles, gaps);
        end
        n_cmp++;
        if (dones != 1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_done: dones=%0d busy=%b expected 1 0",
                     dones, o_busy);
        end
    endtask

    task automatic test_mid_reset();
        bit ok;
        logic [31:0] d;
        logic [3:0] f;
        bus.o_ready = 1'b0;
        do_start(1, 4, 0, 0);
        send_beat(1, 2, 3, 4, 0, ok);
        send_beat(5, 6, 7, 8, 0, ok);
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({bus.o_valid, o_busy} !== 2'b11) begin
            n_fail++;
            $display("FAIL mrst_pre: got %b expected 11", {bus.o_valid, o_busy});
        end
        #2;
        rstn = 1'b0;
        #1;
        f = {bus.o_valid, o_busy, bus.in_ready, o_done};
        n_cmp++;
        if (f !== 4'b0000 || bus.o_data !== 32'h0) begin
            n_fail++;
            $display("FAIL mrst_flush: flags=%b data=%h expected 0000 00000000",
                     f, bus.o_data);
        end
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        do_start(1, 1, 0, 0);
        send_beat(42, -3, 0, 127, 0, ok);
        pop_word(d, ok);
        n_cmp++;
        if (!ok || d !== 32'h7F00FD2A) begin
            n_fail++;
            $display("FAIL mrst_fresh: got %h ok=%b expected 7f00fd2a", d, ok);
        end
        n_cmp++;
        if (bus.o_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mrst_empty: got o_valid=%b expected 0", bus.o_valid);
        end
    endtask

    initial begin
        test_reset();
        test_accum();
        test_round();
        test_saturate();
        test_backpressure();
        test_stream();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule
